// File: rtl/adc_fifo_scheduler_pkg.sv
// Shared types and constants for the two-channel ADC capture FIFO scheduler.
// Frame state encoding, pair width and output byte phase.
package adc_fifo_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int PAIR_W = 16;

    localparam logic PH_H = 1'b0;
    localparam logic PH_L = 1'b1;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] l;
    } pair_t;

endpackage

// File: rtl/adc_fifo_scheduler_pair_queue.sv
// Per-channel pair buffer: small synchronous FIFO with first-word-fall-through read
// so the head entry is visible the cycle after it is pushed.
module pair_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adc_fifo_scheduler.sv
// Buffers tagged byte pairs from two ADC packers, arbitrates round-robin and writes each
// pair to a shared byte FIFO as H then L, under a frame FSM bounding pairs per channel.
module adc_fifo_scheduler
    import adc_fifo_scheduler_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             arm,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [7:0]       ch0_data_h,
    input  logic [7:0]       ch0_data_l,
    input  logic             ch0_wr,
    input  logic [7:0]       ch1_data_h,
    input  logic [7:0]       ch1_data_l,
    input  logic             ch1_wr,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             cur_ch
);
    localparam int QW = $clog2(QDEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_len;
    logic              r_overflow;
    logic              r_last_grant;
    logic              r_pair_valid;
    logic              r_phase;
    logic [7:0]        r_pair_l;
    logic [7:0]        r_wr_data;
    logic              r_cur_ch;

    logic [1:0]        w_ch_wr;
    logic [PAIR_W-1:0] w_ch_pair [2];
    logic [PAIR_W-1:0] w_q_data [2];
    logic [QW:0]       w_q_count [2];
    logic [1:0]        w_q_full;
    logic [1:0]        w_q_empty;
    logic [1:0]        w_q_ready;
    logic [1:0]        w_q_push;
    logic [1:0]        w_q_pop;
    logic [1:0]        w_at_len;
    logic [1:0]        w_drop;
    logic              w_arm_ok;
    logic              w_capture;
    logic              w_engine;
    logic              w_free;
    logic              w_load;
    logic              w_grant;
    pair_t             w_sel;

    assign w_ch_wr      = {ch1_wr, ch0_wr};
    assign w_ch_pair[0] = {ch0_data_h, ch0_data_l};
    assign w_ch_pair[1] = {ch1_data_h, ch1_data_l};
    assign w_arm_ok     = (r_state == IDLE) & arm;
    assign w_capture    = (r_state == CAPTURE);
    assign w_engine     = (r_state == CAPTURE) | (r_state == DRAIN);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             w_take;

            // A pair offered while the queue is full still counts, so the frame can end.
            assign w_at_len[gi]  = (r_cnt == r_len);
            assign w_take        = w_capture & w_ch_wr[gi] & ~w_at_len[gi];
            assign w_q_push[gi]  = w_take & ~w_q_full[gi];
            assign w_drop[gi]    = w_take & w_q_full[gi];
            assign w_q_ready[gi] = (w_q_count[gi] != '0);

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_cnt <= '0;
                end else if (w_arm_ok) begin
                    r_cnt <= '0;
                end else if (w_take) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            pair_queue #(
                .DEPTH (QDEPTH),
                .W     (PAIR_W)
            ) u_queue (
                .clk     (sys_clk),
                .rst     (sys_rst),
                .i_push  (w_q_push[gi]),
                .i_data  (w_ch_pair[gi]),
                .i_pop   (w_q_pop[gi]),
                .o_data  (w_q_data[gi]),
                .o_full  (w_q_full[gi]),
                .o_empty (w_q_empty[gi]),
                .o_count (w_q_count[gi])
            );
        end
    endgenerate

    // The pair register frees up on the accepted L write, allowing a same-cycle reload.
    assign fifo_wr_en = r_pair_valid & ~fifo_full;
    assign w_free     = ~r_pair_valid | (fifo_wr_en & (r_phase == PH_L));
    assign w_load     = w_engine & w_free & (|w_q_ready);
    assign w_grant    = (&w_q_ready) ? ~r_last_grant : ~w_q_ready[0];
    assign w_q_pop    = {w_load & w_grant, w_load & ~w_grant};
    assign w_sel      = w_q_data[w_grant];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (arm) w_state_next = (frame_len == '0) ? DONE : CAPTURE;
            CAPTURE: if (&w_at_len) w_state_next = DRAIN;
            DRAIN:   if ((&w_q_empty) && !r_pair_valid) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_arm_ok) begin
                r_len      <= frame_len;
                r_overflow <= 1'b0;
            end else if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pair_valid <= 1'b0;
            r_phase      <= PH_H;
            r_pair_l     <= '0;
            r_wr_data    <= '0;
            r_cur_ch     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_load) begin
            r_pair_valid <= 1'b1;
            r_phase      <= PH_H;
            r_wr_data    <= w_sel.h;
            r_pair_l     <= w_sel.l;
            r_cur_ch     <= w_grant;
            r_last_grant <= w_grant;
        end else if (fifo_wr_en) begin
            if (r_phase == PH_H) begin
                r_phase   <= PH_L;
                r_wr_data <= r_pair_l;
            end else begin
                r_pair_valid <= 1'b0;
            end
        end
    end

    assign fifo_wr_data = r_wr_data;
    assign cur_ch       = r_cur_ch;
    assign busy         = w_engine;
    assign done         = (r_state == DONE);
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_adc_fifo_scheduler.sv
// Directed bench for adc_fifo_scheduler: per-channel expected-pair queues are filled as
// strobes are driven and matched against the H/L byte pairs captured from the FIFO port.
module tb_adc_fifo_scheduler;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             arm = 1'b0;
    logic [CNT_W-1:0] frame_len = '0;
    logic [7:0]       ch0_data_h = '0;
    logic [7:0]       ch0_data_l = '0;
    logic             ch0_wr = 1'b0;
    logic [7:0]       ch1_data_h = '0;
    logic [7:0]       ch1_data_l = '0;
    logic             ch1_wr = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [7:0]       fifo_wr_data;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             cur_ch;

    int total = 0;
    int bad   = 0;

    logic [8:0]  obs_q [$];
    int          obs_rd = 0;
    int          done_cnt = 0;
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];

    always #5 sys_clk = ~sys_clk;

    adc_fifo_scheduler #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .arm          (arm),
        .frame_len    (frame_len),
        .ch0_data_h   (ch0_data_h),
        .ch0_data_l   (ch0_data_l),
        .ch0_wr       (ch0_wr),
        .ch1_data_h   (ch1_data_h),
        .ch1_data_l   (ch1_data_l),
        .ch1_wr       (ch1_wr),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .cur_ch       (cur_ch)
    );

    always @(negedge sys_clk) begin
        if (fifo_wr_en) obs_q.push_back({cur_ch, fifo_wr_data});
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        exp0.delete();
        exp1.delete();
        obs_rd = obs_q.size();
        tick();
    endtask

    task automatic do_arm(input logic [CNT_W-1:0] len);
        frame_len = len;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic strobe(input bit w0, input bit w1, input logic [15:0] p0,
                          input logic [15:0] p1, input bit record);
        {ch0_data_h, ch0_data_l} = p0;
        {ch1_data_h, ch1_data_l} = p1;
        ch0_wr = w0;
        ch1_wr = w1;
        if (record && w0) exp0.push_back(p0);
        if (record && w1) exp1.push_back(p1);
        tick();
        ch0_wr = 1'b0;
        ch1_wr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge sys_clk);
            if (done) begin
                seen = 1'b1;
                chk("busy_low_in_done", 32'(busy), 32'd0);
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(posedge sys_clk);
        #1;
    endtask

    // Pairs bytes as H,L; lossy mode lets dropped offered pairs be skipped in order.
    task automatic check_pairs(input bit lossy, input bit alt, input int n_bytes);
        logic [8:0]  hb;
        logic [8:0]  lb;
        logic [15:0] pr;
        logic [15:0] e;
        bit          found;
        bit          alt_ch = 1'b0;
        chk("byte_count", 32'(obs_q.size() - obs_rd), 32'(n_bytes));
        while (obs_rd + 1 < obs_q.size()) begin
            hb = obs_q[obs_rd];
            lb = obs_q[obs_rd + 1];
            obs_rd += 2;
            pr = {hb[7:0], lb[7:0]};
            chk("pair_atomic_ch", 32'(lb[8]), 32'(hb[8]));
            if (alt) begin
                chk("alternate_ch", 32'(hb[8]), 32'(alt_ch));
                alt_ch = ~alt_ch;
            end
            found = 1'b0;
            if (!lossy) begin
                if (hb[8] == 1'b0 && exp0.size() > 0) e = exp0.pop_front();
                else if (hb[8] == 1'b1 && exp1.size() > 0) e = exp1.pop_front();
                else e = 16'hxxxx;
                chk("pair_data", 32'(pr), 32'(e));
            end else begin
                while (!found && ((hb[8] ? exp1.size() : exp0.size()) > 0)) begin
                    e = hb[8] ? exp1.pop_front() : exp0.pop_front();
                    if (e == pr) found = 1'b1;
                end
                chk("pair_in_order", 32'(found), 32'd1);
            end
        end
        obs_rd = obs_q.size();
        if (!lossy) chk("pairs_left", 32'(exp0.size() + exp1.size()), 32'd0);
        exp0.delete();
        exp1.delete();
    endtask

    initial begin
        int  d0;
        bit  seen;
        logic h_ch;

        // Reset state
        tick();
        chk("reset_outputs", {26'd0, busy, done, overflow, fifo_wr_en, cur_ch, |fifo_wr_data}, 32'd0);
        sys_rst = 1'b0;
        tick();
        $display("step reset: outputs checked");

        // Frame of 3: ch0 alone cannot end the frame
        d0 = done_cnt;
        do_arm(16'd3);
        chk("busy_after_arm", 32'(busy), 32'd1);
        strobe(1, 0, 16'h411F, 16'h0, 1); tick(); tick(); tick();
        strobe(1, 0, 16'h4200, 16'h0, 1); tick(); tick(); tick();
        strobe(1, 0, 16'h4305, 16'h0, 1);
        repeat (10) tick();
        chk("no_done_ch1_idle", 32'(done_cnt - d0), 32'd0);
        chk("busy_while_waiting", 32'(busy), 32'd1);
        chk("ch0_bytes_out", 32'(obs_q.size() - obs_rd), 32'd6);
        strobe(0, 1, 16'h0, 16'h9001, 1); tick(); tick(); tick();
        strobe(0, 1, 16'h0, 16'h9102, 1); tick(); tick(); tick();
        strobe(0, 1, 16'h0, 16'h9203, 1);
        wait_done(40);
        repeat (3) tick();
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("overflow_clean", 32'(overflow), 32'd0);
        check_pairs(0, 0, 12);
        $display("step frame3: 12 bytes checked");

        // Both channels every cycle into depth-4 queues
        do_reset();
        do_arm(16'd8);
        for (int i = 0; i < 8; i++)
            strobe(1, 1, {8'hA0 + 8'(i), 8'(i)}, {8'hB0 + 8'(i), 8'h10 + 8'(i)}, 1);
        wait_done(100);
        chk("overflow_set", 32'(overflow), 32'd1);
        check_pairs(1, 1, 22);
        tick();
        chk("overflow_holds", 32'(overflow), 32'd1);
        $display("step contention: alternation and overflow checked");

        // Full stall between H and L
        do_arm(16'd1);
        chk("overflow_cleared_by_arm", 32'(overflow), 32'd0);
        strobe(1, 1, 16'h1122, 16'h3344, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            if (fifo_wr_en) seen = 1'b1;
        end
        chk("h_write_seen", 32'(seen), 32'd1);
        h_ch = cur_ch;
        @(posedge sys_clk); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        @(posedge sys_clk); #1;
        fifo_full = 1'b0;
        @(negedge sys_clk);
        chk("post_stall_en", 32'(fifo_wr_en), 32'd1);
        chk("post_stall_ch", 32'(cur_ch), 32'(h_ch));
        chk("post_stall_l_byte", 32'(fifo_wr_data), h_ch ? 32'h44 : 32'h22);
        wait_done(40);
        check_pairs(0, 0, 4);
        $display("step stall: L byte follows H after stall");

        // Zero-length frame
        do_arm(16'd0);
        chk("zero_len_done", 32'(done), 32'd1);
        chk("zero_len_busy", 32'(busy), 32'd0);
        tick();
        chk("zero_len_done_fall", 32'(done), 32'd0);
        chk("zero_len_busy_after", 32'(busy), 32'd0);
        chk("zero_len_no_writes", 32'(obs_q.size() - obs_rd), 32'd0);
        $display("step zero_len: single done pulse");

        // Reset mid-DRAIN with 3 pairs queued
        fifo_full = 1'b1;
        do_arm(16'd2);
        strobe(1, 1, 16'hDEAD, 16'hBEEF, 0);
        strobe(1, 1, 16'hCAFE, 16'hF00D, 0);
        tick(); tick();
        chk("drain_busy", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        #1;
        fifo_full = 1'b0;
        #1;
        chk("midframe_rst_outputs", {26'd0, busy, done, overflow, fifo_wr_en, cur_ch, |fifo_wr_data}, 32'd0);
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        do_arm(16'd1);
        strobe(1, 0, 16'h5AA5, 16'h0, 1);
        repeat (10) tick();
        check_pairs(0, 0, 2);
        $display("step midframe_reset: only new pair emitted");

        // arm during CAPTURE is ignored
        do_reset();
        d0 = done_cnt;
        do_arm(16'd2);
        do_arm(16'd1);
        strobe(1, 1, 16'h6071, 16'h8293, 1);
        repeat (10) tick();
        chk("rearm_ignored_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rearm_ignored_busy", 32'(busy), 32'd1);
        strobe(1, 1, 16'h6172, 16'h8394, 1);
        wait_done(40);
        check_pairs(0, 0, 8);
        $display("step rearm: original frame_len governed");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_fifo_scheduler.md
# adc_fifo_scheduler

Shares a single byte-wide capture FIFO between two packed ADC channels. Each channel's packer delivers a tagged high/low byte pair with a one-cycle write strobe. This block buffers the pairs per channel, arbitrates round-robin, and serializes every pair as two consecutive FIFO writes, high byte first. A frame state machine bounds each capture to a programmed number of pairs per channel and reports completion and overflow to the host-side readout logic.

## Interface
Parameters:
- QDEPTH, 4, pair entries buffered per channel (power of two, ≥2)
- CNT_W, 16, width of frame length and pair counters

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; starts a frame (honoured only in IDLE)
- frame_len  in  CNT_W  pairs to accept per channel; latched on arm
- ch0_data_h, ch0_data_l  in  8 each  channel 0 packed bytes
- ch0_wr  in  1  channel 0 pair strobe (one cycle per pair)
- ch1_data_h, ch1_data_l, ch1_wr  in  8/8/1  channel 1, same semantics
- fifo_full  in  1  downstream FIFO full
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  8  FIFO write byte
- busy  out  1  high in CAPTURE and DRAIN
- done  out  1  one-cycle pulse at frame end
- overflow  out  1  sticky; a pair was dropped this frame
- cur_ch  out  1  channel owning the byte on fifo_wr_data

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE. All outputs reset to 0; reset goes to IDLE, empties both queues, and sets last_grant to 1.
- IDLE: chN_wr is ignored. arm latches frame_len, clears both accept counters and overflow, then branches:
  - frame_len=0: go to DONE.
  - otherwise: go to CAPTURE.
- CAPTURE, per channel:
  - chN_wr with accept count < frame_len and queue not full: push {h,l} and increment the count.
  - chN_wr with queue full: drop the pair, set overflow, and still increment the count, so the frame terminates.
  - Fullness is the registered count before any same-cycle pop.
  - chN_wr with count = frame_len: ignored, no overflow.
- CAPTURE → DRAIN when both counts equal frame_len.
- Output engine, active in CAPTURE and DRAIN:
  - Pair register holds {h,l,ch} and a phase bit.
  - When the pair register is empty, load from a non-empty queue. If both queues are non-empty, grant the channel ≠ last_grant, then update last_grant.
  - Phase H, then phase L. fifo_wr_en = pair_valid & ~fifo_full. The phase advances only on an accepted write.
  - A pair is atomic: no other channel's byte may appear between its H and L, whatever the full stalls.
  - The register reloads in the same cycle the L write is accepted, so back-to-back pairs stream at one byte per cycle.
- DRAIN → DONE when both queues and the pair register are empty.
- DONE: done=1 for one cycle, busy=0, then IDLE. overflow holds until the next accepted arm.
- arm outside IDLE is ignored. Reset mid-frame discards all buffered data without emitting a partial pair.

## Timing
- chN_wr at edge k pushes at k. Pair register loads at k+1. H write is presented in the cycle after k+1 and L in the next cycle, if fifo_full is low. Minimum strobe-to-H latency is 2 cycles.
- fifo_wr_en is combinational from the registered pair state and fifo_full; fifo_wr_data and cur_ch are registered.
- Throughput: 2 bytes per pair. Sustained aggregate strobe rate ≤ 1 pair every 2 cycles is lossless.
- busy rises the cycle after arm, and falls in the DONE cycle.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2, DONE=2'd3)
  - PAIR_W=16
  - phase constants PH_H/PH_L
- One sub-module: pair_queue, a QDEPTH×16 synchronous FIFO with push/pop/full/empty/count. It is instantiated once per channel.
- The arbiter, pair register and frame FSM are all in the top level.

## Test plan
- arm with frame_len=3; ch0 strobes 0x41/0x1F,0x42/0x00,0x43/0x05 every 4 cycles; ch1 idle → ch0 pairs are accepted but ch1 never reaches 3, so the frame does not end. Then 3 ch1 strobes → 12 bytes, H before L per pair, one done pulse, overflow=0.
- Simultaneous ch0_wr/ch1_wr every cycle, frame_len=8, QDEPTH=4 → writes strictly alternate ch0,ch1 pairs starting with ch0, overflow=1, done after the drain.
- fifo_full held high for 10 cycles after an H write → fifo_wr_en=0 throughout; the next write is that pair's L byte with the same cur_ch.
- frame_len=0 then arm → done pulses 1 cycle after arm; no FIFO writes; busy stays 0.
- sys_rst asserted mid-DRAIN with 3 pairs queued → all outputs 0 immediately; a subsequent arm with frame_len=1 emits exactly 2 bytes from new strobes only.
- arm pulse during CAPTURE with a new frame_len=1 → ignored; the original frame_len governs termination.
